alu_req_arbiter: RTL

//  Shares one 64-bit ALU (ADD/SUB/AND/XOR) between two requesters (req0, req1).

---
 rtl/alu_req_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU (ADD/SUB/AND/XOR) between two requesters.
// Round-robin grant, valid/ready on both request ports and the response port,
// registered result with OF/ZF/SF flags and the id of the winning requester.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req0_valid/ready/op/a/b     requester 0 (op: 00 ADD, 01 SUB, 10 AND, 11 XOR)
//   req1_valid/ready/op/a/b     requester 1
//   rsp_valid, rsp_ready        response handshake
//   rsp_id                      winning requester of the held result
//   rsp_result, rsp_of/zf/sf    registered result and condition flags
module alu_req_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_of,
  output logic             rsp_zf,
  output logic             rsp_sf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic             prio;
  logic             can_accept;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;

  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] xor_bits;
  logic [WIDTH-1:0] alu_r;
  logic             alu_of;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a consumed result with a same-cycle accept stays in HOLD
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = HOLD;
      HOLD: if (rsp_ready && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/grant logic: the HOLD slot frees in the cycle it is consumed
  always_comb begin
    can_accept  = 1'b0;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    can_accept = (state == IDLE) || rsp_ready;

    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = prio;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end

    // Reset suppresses any handshake so nothing is lost while the block clears
    accept     = can_accept && grant_valid && !reset;
    req0_ready = accept && (grant_id == 1'b0);
    req1_ready = accept && (grant_id == 1'b1);
  end

  assign rsp_valid = (state == HOLD);

  // Operand mux toward the shared ALU
  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

  // Bitwise units, one cell per bit
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bitwise
    assign and_bits[i] = sel_a[i] & sel_b[i];
    assign xor_bits[i] = sel_a[i] ^ sel_b[i];
  end

  // Arithmetic: carry-out discarded, overflow from operand/result signs
  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    case (sel_op)
      OP_ADD: begin
        alu_r  = sel_a + sel_b;
        alu_of = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) && (alu_r[WIDTH-1] != sel_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r  = sel_a - sel_b;
        alu_of = (sel_a[WIDTH-1] != sel_b[WIDTH-1]) && (alu_r[WIDTH-1] != sel_a[WIDTH-1]);
      end
      OP_AND: alu_r = and_bits;
      OP_XOR: alu_r = xor_bits;
      default: alu_r = '0;
    endcase
  end

  // Response registers and round-robin pointer; untouched unless an op is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      prio       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_of     <= 1'b0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
    end else if (accept) begin
      prio       <= ~grant_id;
      rsp_id     <= grant_id;
      rsp_result <= alu_r;
      rsp_of     <= alu_of;
      rsp_zf     <= (alu_r == '0);
      rsp_sf     <= alu_r[WIDTH-1];
    end
  end

endmodule
